// File: rtl/trigger_ctrl.sv
// Trigger controller for the ADC capture path: level crossing with hysteresis,
// slope select, monotonic run qualifier, holdoff and auto/normal/single modes.
module trigger_ctrl #(
    parameter int DW     = 8,
    parameter int RUN    = 3,
    parameter int HOLD_W = 16,
    parameter int AUTO_W = 20
) (
    input  logic              clk_AD,
    input  logic              rst,
    input  logic [DW-1:0]     trigger_DI,
    input  logic [DW-1:0]     level,
    input  logic [DW-1:0]     hyst,
    input  logic              slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic [AUTO_W-1:0] auto_timeout,
    output logic              trigger,
    output logic              trig_auto,
    output logic              armed
);

    localparam int FILL_W = $clog2(RUN + 2);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(RUN + 1);
    localparam logic [DW:0] SAMPLE_MAX = {1'b0, {DW{1'b1}}};
    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_OFF = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PRIMED,
        S_HOLDOFF,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DW-1:0]       r_s [0:RUN];
    logic [FILL_W-1:0]   r_fill;
    logic [HOLD_W-1:0]   r_hold;
    logic [AUTO_W-1:0]   r_auto;

    logic [DW:0]         w_sum;
    logic [DW:0]         w_lo;
    logic [DW:0]         w_hi;
    logic                w_full;
    logic                w_rise_mono;
    logic                w_fall_mono;
    logic                w_prime;
    logic                w_fire;
    logic                w_auto_hit;
    logic                w_trig;
    logic                w_auto_fire;
    logic                w_waiting;
    logic                w_next_waiting;

    always_ff @(posedge clk_AD or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= RUN; i++) begin
                r_s[i] <= '0;
            end
            r_fill <= '0;
        end else begin
            r_s[0] <= trigger_DI;
            for (int i = 1; i <= RUN; i++) begin
                r_s[i] <= r_s[i-1];
            end
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    assign w_full = (r_fill == FILL_MAX);

    // Thresholds are one bit wider so the band saturates instead of wrapping
    assign w_sum = {1'b0, level} + {1'b0, hyst};
    assign w_hi  = (w_sum > SAMPLE_MAX) ? SAMPLE_MAX : w_sum;
    assign w_lo  = (hyst > level) ? '0 : ({1'b0, level} - {1'b0, hyst});

    always_comb begin
        w_rise_mono = 1'b1;
        w_fall_mono = 1'b1;
        for (int i = 0; i < RUN; i++) begin
            if (r_s[i] < r_s[i+1]) begin
                w_rise_mono = 1'b0;
            end
            if (r_s[i] > r_s[i+1]) begin
                w_fall_mono = 1'b0;
            end
        end
    end

    always_comb begin
        w_prime = 1'b0;
        w_fire  = 1'b0;
        if (w_full) begin
            if (slope) begin
                w_prime = ({1'b0, r_s[0]} >= w_hi);
                w_fire  = (r_s[0] <= level) && w_fall_mono;
            end else begin
                w_prime = ({1'b0, r_s[0]} <= w_lo);
                w_fire  = (r_s[0] >= level) && w_rise_mono;
            end
        end
    end

    assign w_auto_hit = (mode == MODE_AUTO) && (auto_timeout != '0) && (r_auto == auto_timeout);

    always_comb begin
        w_next      = r_state;
        w_trig      = 1'b0;
        w_auto_fire = 1'b0;
        if (mode == MODE_OFF) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next = S_ARMED;
                end
                S_ARMED: begin
                    if (w_auto_hit) begin
                        w_next      = S_HOLDOFF;
                        w_trig      = 1'b1;
                        w_auto_fire = 1'b1;
                    end else if (w_prime) begin
                        w_next = S_PRIMED;
                    end
                end
                S_PRIMED: begin
                    if (w_fire) begin
                        w_next = S_HOLDOFF;
                        w_trig = 1'b1;
                    end else if (w_auto_hit) begin
                        w_next      = S_HOLDOFF;
                        w_trig      = 1'b1;
                        w_auto_fire = 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold == '0) begin
                        w_next = (mode == MODE_SINGLE) ? S_DONE : S_ARMED;
                    end
                end
                S_DONE: begin
                    if (arm) begin
                        w_next = S_ARMED;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    assign w_waiting      = (r_state == S_ARMED) || (r_state == S_PRIMED);
    assign w_next_waiting = (w_next == S_ARMED) || (w_next == S_PRIMED);

    always_ff @(posedge clk_AD or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            trigger   <= 1'b0;
            trig_auto <= 1'b0;
            armed     <= 1'b0;
        end else begin
            r_state   <= w_next;
            trigger   <= w_trig;
            trig_auto <= w_auto_fire;
            armed     <= w_next_waiting;
        end
    end

    // Auto counter only runs while staying inside ARMED/PRIMED, so entry clears it
    always_ff @(posedge clk_AD or posedge rst) begin
        if (rst) begin
            r_auto <= '0;
            r_hold <= '0;
        end else begin
            if (w_waiting && w_next_waiting) begin
                if (r_auto != {AUTO_W{1'b1}}) begin
                    r_auto <= r_auto + AUTO_W'(1);
                end
            end else begin
                r_auto <= '0;
            end
            if (w_trig) begin
                r_hold <= holdoff;
            end else if ((r_state == S_HOLDOFF) && (r_hold != '0)) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed-vector bench for trigger_ctrl: each task drives a scenario and
// compares pulse counts, pulse positions and the armed flag against hand values.
module tb_trigger_ctrl;

    logic        clk_AD = 1'b0;
    logic        rst;
    logic [7:0]  trigger_DI;
    logic [7:0]  level;
    logic [7:0]  hyst;
    logic        slope;
    logic [1:0]  mode;
    logic        arm;
    logic [15:0] holdoff;
    logic [19:0] auto_timeout;
    logic        trigger;
    logic        trig_auto;
    logic        armed;

    int total = 0;
    int bad = 0;

    logic [7:0] seqQ[$];
    int pulseIdx[$];
    int pulses;
    int autoCnt;

    trigger_ctrl #(
        .DW(8),
        .RUN(3),
        .HOLD_W(16),
        .AUTO_W(20)
    ) dut (
        .clk_AD(clk_AD),
        .rst(rst),
        .trigger_DI(trigger_DI),
        .level(level),
        .hyst(hyst),
        .slope(slope),
        .mode(mode),
        .arm(arm),
        .holdoff(holdoff),
        .auto_timeout(auto_timeout),
        .trigger(trigger),
        .trig_auto(trig_auto),
        .armed(armed)
    );

    always #5 clk_AD = ~clk_AD;

    // One sample per clock; outputs are read 1 time unit after the edge
    task automatic applyStimulus(input logic [7:0] v, output logic t, output logic ta);
        trigger_DI = v;
        @(posedge clk_AD);
        #1;
        t = trigger;
        ta = trig_auto;
    endtask

    task automatic addRep(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            seqQ.push_back(v);
        end
    endtask

    task automatic runSeq();
        logic t;
        logic ta;
        pulses = 0;
        autoCnt = 0;
        pulseIdx.delete();
        for (int i = 0; i < seqQ.size(); i++) begin
            applyStimulus(seqQ[i], t, ta);
            if (t === 1'b1) begin
                pulses++;
                pulseIdx.push_back(i);
            end
            if (ta === 1'b1) begin
                autoCnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic t;
        logic ta;
        rst = 1'b1;
        trigger_DI = 8'd100;
        level = 8'd128;
        hyst = 8'd8;
        slope = 1'b0;
        mode = 2'b01;
        arm = 1'b0;
        holdoff = 16'd2;
        auto_timeout = 20'd0;
        repeat (3) @(posedge clk_AD);
        #1;
        total++;
        if (trigger !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_trigger: got %b expected 0", trigger);
        end
        total++;
        if (trig_auto !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_trig_auto: got %b expected 0", trig_auto);
        end
        total++;
        if (armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_armed: got %b expected 0", armed);
        end
        rst = 1'b0;
        applyStimulus(8'd100, t, ta);
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_first_arm: got %b expected 1", armed);
        end
    endtask

    task automatic test_rising();
        seqQ.delete();
        addRep(8'd100, 5);
        addRep(8'd110, 1);
        addRep(8'd120, 1);
        addRep(8'd130, 1);
        addRep(8'd140, 3);
        runSeq();
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("[TB] FAIL rise_count: got %0d expected 1", pulses);
        end
        total++;
        if (pulseIdx.size() < 1 || pulseIdx[0] != 8) begin
            bad++;
            $display("[TB] FAIL rise_position: got %0d expected 8", (pulseIdx.size() > 0) ? pulseIdx[0] : -1);
        end
        total++;
        if (autoCnt !== 0) begin
            bad++;
            $display("[TB] FAIL rise_auto_flag: got %0d expected 0", autoCnt);
        end
        total++;
        if (armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rise_holdoff_armed: got %b expected 0", armed);
        end
    endtask

    task automatic test_hysteresis();
        seqQ.delete();
        addRep(8'd100, 5);
        for (int i = 0; i < 6; i++) begin
            addRep(8'd130, 1);
            addRep(8'd126, 1);
        end
        addRep(8'd120, 4);
        addRep(8'd130, 2);
        runSeq();
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("[TB] FAIL hyst_count: got %0d expected 2", pulses);
        end
        total++;
        if (pulseIdx.size() < 1 || pulseIdx[0] != 6) begin
            bad++;
            $display("[TB] FAIL hyst_first: got %0d expected 6", (pulseIdx.size() > 0) ? pulseIdx[0] : -1);
        end
        total++;
        if (pulseIdx.size() < 2 || pulseIdx[1] != 22) begin
            bad++;
            $display("[TB] FAIL hyst_reprime: got %0d expected 22", (pulseIdx.size() > 1) ? pulseIdx[1] : -1);
        end
    endtask

    task automatic test_run_qualifier();
        logic t;
        logic ta;
        seqQ.delete();
        addRep(8'd130, 4);
        addRep(8'd110, 1);
        addRep(8'd105, 1);
        addRep(8'd100, 1);
        addRep(8'd140, 1);
        addRep(8'd125, 1);
        addRep(8'd135, 1);
        addRep(8'd120, 1);
        runSeq();
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("[TB] FAIL run_count: got %0d expected 0", pulses);
        end
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("[TB] FAIL run_still_primed: got %b expected 1", armed);
        end
        mode = 2'b11;
        applyStimulus(8'd120, t, ta);
        total++;
        if (armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL run_disable: got %b expected 0", armed);
        end
    endtask

    task automatic test_falling();
        slope = 1'b1;
        mode = 2'b01;
        seqQ.delete();
        addRep(8'd160, 5);
        addRep(8'd150, 1);
        addRep(8'd140, 1);
        addRep(8'd130, 1);
        addRep(8'd120, 2);
        runSeq();
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("[TB] FAIL fall_count: got %0d expected 1", pulses);
        end
        total++;
        if (pulseIdx.size() < 1 || pulseIdx[0] != 9) begin
            bad++;
            $display("[TB] FAIL fall_position: got %0d expected 9", (pulseIdx.size() > 0) ? pulseIdx[0] : -1);
        end
    endtask

    task automatic test_auto();
        logic t;
        logic ta;
        int expIdx[3];
        expIdx[0] = 51;
        expIdx[1] = 106;
        expIdx[2] = 161;
        mode = 2'b11;
        applyStimulus(8'd64, t, ta);
        slope = 1'b0;
        mode = 2'b00;
        holdoff = 16'd3;
        auto_timeout = 20'd50;
        seqQ.delete();
        addRep(8'd64, 170);
        runSeq();
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("[TB] FAIL auto_count: got %0d expected 3", pulses);
        end
        total++;
        if (autoCnt !== 3) begin
            bad++;
            $display("[TB] FAIL auto_flag_count: got %0d expected 3", autoCnt);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pulseIdx.size() <= k || pulseIdx[k] != expIdx[k]) begin
                bad++;
                $display("[TB] FAIL auto_position_%0d: got %0d expected %0d", k, (pulseIdx.size() > k) ? pulseIdx[k] : -1, expIdx[k]);
            end
        end
        auto_timeout = 20'd0;
    endtask

    task automatic test_single();
        logic t;
        logic ta;
        mode = 2'b11;
        applyStimulus(8'd100, t, ta);
        mode = 2'b10;
        holdoff = 16'd10;
        seqQ.delete();
        addRep(8'd100, 5);
        addRep(8'd110, 1);
        addRep(8'd120, 1);
        addRep(8'd130, 1);
        addRep(8'd140, 16);
        runSeq();
        total++;
        if (pulses !== 1 || pulseIdx.size() < 1 || pulseIdx[0] != 8) begin
            bad++;
            $display("[TB] FAIL single_first: got count %0d expected 1 at index 8", pulses);
        end
        total++;
        if (armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_done_armed: got %b expected 0", armed);
        end
        runSeq();
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("[TB] FAIL single_no_rearm: got %0d expected 0", pulses);
        end
        arm = 1'b1;
        applyStimulus(8'd140, t, ta);
        arm = 1'b0;
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_arm: got %b expected 1", armed);
        end
        seqQ.delete();
        addRep(8'd100, 5);
        addRep(8'd110, 1);
        addRep(8'd120, 1);
        addRep(8'd130, 1);
        addRep(8'd140, 2);
        runSeq();
        total++;
        if (pulses !== 1 || pulseIdx.size() < 1 || pulseIdx[0] != 8) begin
            bad++;
            $display("[TB] FAIL single_rearmed: got count %0d expected 1 at index 8", pulses);
        end
        mode = 2'b11;
        applyStimulus(8'd140, t, ta);
        total++;
        if (armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_force_idle: got %b expected 0", armed);
        end
        mode = 2'b10;
        applyStimulus(8'd140, t, ta);
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_idle_rearm: got %b expected 1", armed);
        end
    endtask

    task automatic test_reset_mid_ramp();
        seqQ.delete();
        addRep(8'd100, 5);
        addRep(8'd110, 1);
        runSeq();
        rst = 1'b1;
        #2;
        total++;
        if (trigger !== 1'b0 || armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_clear: got trigger %b armed %b expected 0 0", trigger, armed);
        end
        @(posedge clk_AD);
        #1;
        rst = 1'b0;
        seqQ.delete();
        addRep(8'd120, 1);
        addRep(8'd130, 1);
        addRep(8'd140, 1);
        addRep(8'd150, 1);
        addRep(8'd160, 1);
        addRep(8'd100, 1);
        addRep(8'd110, 1);
        addRep(8'd120, 1);
        addRep(8'd130, 1);
        addRep(8'd140, 1);
        runSeq();
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("[TB] FAIL midreset_count: got %0d expected 1", pulses);
        end
        total++;
        if (pulseIdx.size() < 1 || pulseIdx[0] != 9) begin
            bad++;
            $display("[TB] FAIL midreset_position: got %0d expected 9", (pulseIdx.size() > 0) ? pulseIdx[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_hysteresis();
        test_run_qualifier();
        test_falling();
        test_auto();
        test_single();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trigger_ctrl.md
# trigger_ctrl

Parametrised trigger controller for the ADC capture path, running in the ADC sample clock domain. It compares the incoming sample stream against a programmable level and applies hysteresis, a slope select and a monotonic run-length qualifier. A holdoff counter and auto/normal/single acquisition modes gate when the trigger may fire. Its `trigger` pulse starts a capture into the sample buffer that feeds the VGA waveform display.

## Interface
Parameters:
- `DW` = 8 — sample width.
- `RUN` = 3 — number of consecutive monotonic steps required before the crossing (≥1).
- `HOLD_W` = 16 — holdoff counter width.
- `AUTO_W` = 20 — auto-timeout counter width.

Ports:
- `clk_AD` in 1 — ADC sample clock, the only clock.
- `rst` in 1 — asynchronous, active-high reset.
- `trigger_DI` in DW — unsigned ADC sample, one per clock.
- `level` in DW — trigger level.
- `hyst` in DW — hysteresis band.
- `slope` in 1 — 0 = rising, 1 = falling.
- `mode` in 2 — 00 auto, 01 normal, 10 single, 11 disabled.
- `arm` in 1 — single-shot re-arm strobe.
- `holdoff` in HOLD_W — holdoff length in cycles.
- `auto_timeout` in AUTO_W — auto-mode timeout in cycles.
- `trigger` out 1 — one-cycle trigger pulse.
- `trig_auto` out 1 — high together with `trigger` when the trigger was forced by timeout.
- `armed` out 1 — high in ARMED or PRIMED.

## Operation
- Sample history: shift register `s[0..RUN]`; `s[0]` is newest and loads `trigger_DI` every clock.
- History fill: a fill counter saturates at RUN+1. Crossing detection is blocked until RUN+1 samples have been captured since reset.
- Thresholds, computed DW+1 bits wide and saturated:
  - `lo = max(level − hyst, 0)`
  - `hi = min(level + hyst, 2^DW − 1)`
- Rising (`slope` = 0):
  - prime when `s[0] <= lo`;
  - fire when `s[0] >= level` and `s[i] >= s[i+1]` for all i = 0..RUN−1.
- Falling (`slope` = 1):
  - prime when `s[0] >= hi`;
  - fire when `s[0] <= level` and `s[i] <= s[i+1]` for all i.
- FSM states: IDLE, ARMED, PRIMED, HOLDOFF, DONE.
  - Any state → IDLE when `mode` = 11. This has priority over every other transition.
  - IDLE → ARMED when `mode` ≠ 11.
  - ARMED → PRIMED on the prime condition.
  - PRIMED → HOLDOFF on the fire condition. `trigger` pulses and the holdoff counter loads `holdoff`.
  - ARMED/PRIMED, `mode` = 00, auto counter == `auto_timeout` → HOLDOFF, with `trigger` = `trig_auto` = 1. This fires only if no real fire occurs that cycle; a real fire wins the tie.
  - HOLDOFF: the counter decrements each cycle. At 0: single mode → DONE, otherwise → ARMED.
  - DONE → ARMED on `arm` = 1. `arm` is ignored in every other state.
- Auto counter:
  - clears on entry to ARMED and in all states other than ARMED/PRIMED;
  - counts only in ARMED/PRIMED;
  - saturates at all-ones.
  - `auto_timeout` = 0 disables forced triggers.
- A `slope`, `level` or `hyst` change mid-wait does not reset the FSM. New values apply from the next evaluation.

## Timing
- Reset values: `trigger` = 0, `trig_auto` = 0, `armed` = 0; FSM in IDLE; history, fill, holdoff and auto counters all 0.
- `trigger` and `trig_auto` are registered outputs. A sample presented before edge N sets `trigger` = 1 during the cycle after edge N+1, for exactly one cycle.
- A sample that completes priming cannot itself fire. Firing needs at least one further sample.
- Holdoff occupies `holdoff` + 1 cycles in HOLDOFF, so `holdoff` = 0 gives one cycle. The earliest re-trigger is `holdoff` + 2 cycles after the previous pulse.
- `armed` is registered and reflects the state entered at the same edge.
- Reset asserted mid-capture clears all state immediately. No trigger is emitted until the history refills after release.

## Test plan
- Rising edge, normal mode, RUN = 3, `level` = 128, `hyst` = 8: ramp 100, 110, 120, 130, 140 → `trigger` high exactly once, two cycles after the 130 sample, with `trig_auto` = 0.
- Hysteresis / noise: samples toggle 126 ↔ 130 after priming at 100. Expect one pulse on the first 130 only; no further pulse until a sample ≤ 120 re-primes.
- Run qualifier: sequence 100, 140, 125, 135 (non-monotonic) → no trigger.
- Falling edge, `slope` = 1: ramp 160, 150, 140, 130, 120 → one pulse after 120.
- Auto mode, `auto_timeout` = 50, constant input 64 → `trigger` = `trig_auto` = 1 every 50 + `holdoff` + 2 cycles.
- Single mode, `holdoff` = 10, repeated ramps:
  - exactly one pulse, then `armed` = 0;
  - a one-cycle `arm` pulse re-enables triggering on the next ramp;
  - driving `mode` = 11 during HOLDOFF forces IDLE;
  - asserting `rst` mid-ramp gives no pulse until 4 new samples have been captured.
